// File: rtl/obuft_ctrl_pkg.sv
// Shared definitions for the OBUFT drive/turnaround controller.
//   - State encoding for the drive FSM (HIZ, GUARD, DRIVE, HOLD).
//   - Width of the shared guard/hold down-counter.
//   - Legal-range helpers for the TA_CYCLES and HOLD_CYCLES parameters.
package obuft_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_HIZ   = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  function automatic bit ta_cycles_ok(int unsigned v);
    return (v >= 1) && (v <= 255);
  endfunction

  function automatic bit hold_cycles_ok(int unsigned v);
    return v <= 255;
  endfunction

endpackage

// File: rtl/obuft_ta_counter.sv
// Loadable down-counter shared by the turnaround guard and the post-drive hold.
// Ports:
//   clk      - clock
//   clr      - asynchronous active-high clear (count -> 0)
//   load     - load load_val on the next edge (wins over dec)
//   load_val - value to load
//   dec      - decrement enable; saturates at zero
//   zero     - count is zero
module obuft_ta_counter
  import obuft_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/obuft_drive_ctrl.sv
// Registered drive/turnaround controller feeding a bank of OBUFT tri-state buffers.
// Words arrive over VALID/READY; the bus is only driven after a TA_CYCLES Hi-Z guard,
// and stays driven for HOLD_CYCLES after the last word. Pad-facing outputs are
// registered so they can be packed into IOB flip-flops.
// Ports:
//   C         - clock
//   CLR       - asynchronous active-high reset
//   D         - word to drive
//   VALID     - upstream word valid
//   READY     - combinational; a word is accepted on an edge with VALID & READY
//   FORCE_HIZ - synchronous abort to high-Z
//   O_I       - registered pad data to OBUFT I
//   O_T       - registered tri-state control to OBUFT T (1 = high-Z)
//   BUSY      - registered; high whenever the controller is not idle in HIZ
module obuft_drive_ctrl
  import obuft_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TA_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  input  logic             FORCE_HIZ,
  output logic [WIDTH-1:0] O_I,
  output logic             O_T,
  output logic             BUSY
);

  if (!ta_cycles_ok(TA_CYCLES)) begin : g_bad_ta
    $error("obuft_drive_ctrl: TA_CYCLES must be in 1..255");
  end
  if (!hold_cycles_ok(HOLD_CYCLES)) begin : g_bad_hold
    $error("obuft_drive_ctrl: HOLD_CYCLES must be in 0..255");
  end

  // HOLD_LOAD wraps when HOLD_CYCLES == 0, but the HOLD path is skipped in that case.
  localparam logic [CNT_W-1:0] TA_LOAD   = CNT_W'(TA_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] o_i_q, o_i_d;
  logic             o_t_q, o_t_d;
  logic             busy_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  obuft_ta_counter u_cnt (
    .clk      (C),
    .clr      (CLR),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // READY is forced low during CLR so nothing upstream sees a phantom accept.
  assign READY = ~CLR & ~FORCE_HIZ &
                 (((state_q == ST_GUARD) & cnt_zero) |
                  (state_q == ST_DRIVE) | (state_q == ST_HOLD));

  always_comb begin
    state_d      = state_q;
    o_i_d        = o_i_q;
    o_t_d        = o_t_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (FORCE_HIZ) begin
      // Abort: release the bus, keep the last word on O_I, clear the counter.
      state_d  = ST_HIZ;
      o_t_d    = 1'b1;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        ST_HIZ: begin
          if (VALID) begin
            state_d      = ST_GUARD;
            cnt_load     = 1'b1;
            cnt_load_val = TA_LOAD;
          end
        end
        ST_GUARD: begin
          if (!VALID) begin
            state_d = ST_HIZ;
          end else if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            o_i_d   = D;
            o_t_d   = 1'b0;
          end
        end
        ST_DRIVE: begin
          if (VALID) begin
            o_i_d = D;
          end else if (HOLD_CYCLES == 0) begin
            state_d = ST_HIZ;
            o_t_d   = 1'b1;
          end else begin
            state_d      = ST_HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (VALID) begin
            // Bus is still ours, so a new word re-enters DRIVE without a guard.
            state_d = ST_DRIVE;
            o_i_d   = D;
          end else if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else begin
            state_d = ST_HIZ;
            o_t_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_HIZ;
          o_t_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_HIZ;
      o_i_q   <= '0;
      o_t_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_i_q   <= o_i_d;
      o_t_q   <= o_t_d;
      busy_q  <= (state_d != ST_HIZ);
    end
  end

  assign O_I  = o_i_q;
  assign O_T  = o_t_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_obuft_drive_ctrl.sv
// Bench for obuft_drive_ctrl: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the bus-ownership rules.
module tb_obuft_drive_ctrl;

  localparam int WIDTH = 8;
  localparam int TA    = 2;
  localparam int HOLD  = 1;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] in_d;
  logic             in_valid;
  logic             in_force;
  logic             ready;
  logic [WIDTH-1:0] o_i;
  logic             o_t;
  logic             busy;

  int n_checks;
  int n_fail;

  obuft_drive_ctrl #(
    .WIDTH       (WIDTH),
    .TA_CYCLES   (TA),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .C         (clk),
    .CLR       (clr),
    .D         (in_d),
    .VALID     (in_valid),
    .READY     (ready),
    .FORCE_HIZ (in_force),
    .O_I       (o_i),
    .O_T       (o_t),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who owns the bus and how long it has been in the current phase.
  // phase: 0 = released, 1 = waiting out turnaround, 2 = driving words, 3 = lingering.
  int               m_phase;
  int               m_elapsed;
  logic [WIDTH-1:0] m_oi;
  logic             m_ot;
  bit               last_acc;

  function automatic bit m_ready();
    if (clr || in_force) return 1'b0;
    return (m_phase == 1 && m_elapsed == TA - 1) || m_phase == 2 || m_phase == 3;
  endfunction

  task automatic m_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_oi      = '0;
    m_ot      = 1'b1;
  endtask

  // Apply the rules for one clock edge given the inputs present before the edge.
  task automatic m_edge(input bit v, input logic [WIDTH-1:0] d, input bit f);
    last_acc = v && m_ready();
    if (f) begin
      m_phase = 0;
      m_ot    = 1'b1;
      return;
    end
    case (m_phase)
      0: if (v) begin m_phase = 1; m_elapsed = 0; end
      1: begin
        if (!v) m_phase = 0;
        else if (m_elapsed < TA - 1) m_elapsed++;
        else begin m_oi = d; m_ot = 1'b0; m_phase = 2; end
      end
      2: begin
        if (v) m_oi = d;
        else if (HOLD == 0) begin m_ot = 1'b1; m_phase = 0; end
        else begin m_phase = 3; m_elapsed = 0; end
      end
      default: begin
        if (v) begin m_oi = d; m_phase = 2; end
        else if (m_elapsed < HOLD - 1) m_elapsed++;
        else begin m_ot = 1'b1; m_phase = 0; end
      end
    endcase
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check READY, clock, update model, check registered outputs.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit f);
    in_valid = v;
    in_d     = d;
    in_force = f;
    #1;
    check_eq("ready", 32'(ready), 32'(m_ready()));
    @(posedge clk);
    m_edge(v, d, f);
    #1;
    check_eq("o_t", 32'(o_t), 32'(m_ot));
    check_eq("o_i", 32'(o_i), 32'(m_oi));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
  endtask

  task automatic check_reset_values();
    check_eq("rst_o_t", 32'(o_t), 32'd1);
    check_eq("rst_o_i", 32'(o_i), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
  endtask

  initial begin
    bit               v;
    logic [WIDTH-1:0] d;
    n_checks = 0;
    n_fail   = 0;
    last_acc = 1'b0;
    in_valid = 1'b0;
    in_d     = '0;
    in_force = 1'b0;
    clr      = 1'b1;
    m_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Scenario 1: acquisition with D=0xA5 held valid.
    step(1'b1, 8'hA5, 1'b0);  // e0
    check_eq("s1_o_t_e0", 32'(o_t), 32'd1);
    check_eq("s1_busy_e0", 32'(busy), 32'd1);
    step(1'b1, 8'hA5, 1'b0);  // e1
    check_eq("s1_o_t_e1", 32'(o_t), 32'd1);
    step(1'b1, 8'hA5, 1'b0);  // e2
    check_eq("s1_o_t_e2", 32'(o_t), 32'd0);
    check_eq("s1_o_i_e2", 32'(o_i), 32'hA5);

    // Scenario 2: burst, then release through one hold cycle.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    check_eq("s2_o_i", 32'(o_i), 32'h03);
    step(1'b0, 8'h00, 1'b0);
    check_eq("s2_o_t_hold", 32'(o_t), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("s2_o_t_rel", 32'(o_t), 32'd1);
    check_eq("s2_busy_rel", 32'(busy), 32'd0);

    // Scenario 3: re-acquire from HOLD without a guard.
    repeat (3) step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    check_eq("s3_o_i", 32'(o_i), 32'h55);
    check_eq("s3_o_t", 32'(o_t), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Scenario 4: withdraw during GUARD.
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h77, 1'b0);
    check_eq("s4_o_t", 32'(o_t), 32'd1);
    check_eq("s4_o_i", 32'(o_i), 32'h55);
    check_eq("s4_busy", 32'(busy), 32'd0);

    // Scenario 5: FORCE_HIZ mid-drive, then re-acquire through a full guard.
    repeat (3) step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'h3C, 1'b1);
    check_eq("s5_o_t", 32'(o_t), 32'd1);
    check_eq("s5_o_i", 32'(o_i), 32'hC1);
    check_eq("s5_busy", 32'(busy), 32'd0);
    repeat (4) step(1'b1, 8'h3C, 1'b0);
    check_eq("s5_reacq", 32'(o_i), 32'h3C);

    // Scenario 6: asynchronous CLR between edges while driving.
    #2;
    clr = 1'b1;
    #1;
    check_reset_values();
    m_reset();
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 8'h9E, 1'b0);
    check_eq("s6_o_i", 32'(o_i), 32'h9E);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Randomized traffic; D is held while a valid word waits to be taken.
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 500; i++) begin
      bit keep;
      keep = v && !last_acc && ($urandom_range(0, 3) != 0);
      if (!keep) begin
        v = ($urandom_range(0, 9) < 6);
        d = WIDTH'($urandom);
      end
      step(v, d, ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
